// File: rtl/or4_if.sv
// Signal bundle for the or4 leaf cell: four OR inputs plus statistics clear,
// and the combinational/registered observation outputs.
interface or4_if #(
  parameter int CNT_W = 16
);
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             clr;
  logic             y;
  logic             y_q;
  logic             y_rise;
  logic [CNT_W-1:0] hit_cnt;
  logic [3:0]       seen_mask;

  // No handshake: inputs are level signals sampled on every rising clk edge;
  // y is valid in the same timestep, registered outputs one edge later.
  modport master (
    output a, b, c, d, clr,
    input  y, y_q, y_rise, hit_cnt, seen_mask
  );

  modport slave (
    input  a, b, c, d, clr,
    output y, y_q, y_rise, hit_cnt, seen_mask
  );
endinterface

// File: rtl/or4.sv
// Four-input OR with a registered observation side-band: delayed copy, rise
// pulse, saturating hit counter and per-input sticky mask.
module or4 #(
  parameter int CNT_W = 16
) (
  input  logic   clk,
  input  logic   rst,
  or4_if.slave   bus
);
  logic             y_comb;
  logic             y_q_r;
  logic             y_rise_r;
  logic [CNT_W-1:0] hit_cnt_r;
  logic [3:0]       seen_mask_r;
  logic             hit_sat;

  // Pure combinational path; never touched by clk, rst or clr.
  assign y_comb  = bus.a | bus.b | bus.c | bus.d;
  assign hit_sat = (hit_cnt_r == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_r       <= 1'b0;
      y_rise_r    <= 1'b0;
      hit_cnt_r   <= '0;
      seen_mask_r <= 4'b0000;
    end else begin
      y_q_r    <= y_comb;
      y_rise_r <= y_comb & ~y_q_r;
      // Clear beats both the increment and the sticky set on the same edge.
      if (bus.clr) begin
        hit_cnt_r   <= '0;
        seen_mask_r <= 4'b0000;
      end else begin
        if (y_comb && !hit_sat) begin
          hit_cnt_r <= hit_cnt_r + CNT_W'(1);
        end
        seen_mask_r <= seen_mask_r | {bus.d, bus.c, bus.b, bus.a};
      end
    end
  end

  assign bus.y         = y_comb;
  assign bus.y_q       = y_q_r;
  assign bus.y_rise    = y_rise_r;
  assign bus.hit_cnt   = hit_cnt_r;
  assign bus.seen_mask = seen_mask_r;
endmodule

// File: tb/tb_or4.sv
// Directed bench for or4: combinational truth checks, clocked statistics,
// clear/reset priority, and counter saturation on a narrow instance.
module tb_or4;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [0:0] exp_q[$];

  or4_if #(.CNT_W(16)) bus ();
  or4_if #(.CNT_W(2))  bus_s ();

  or4 #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  or4 #(.CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [3:0] dcba, input logic clr_v);
    bus.a   = dcba[0];
    bus.b   = dcba[1];
    bus.c   = dcba[2];
    bus.d   = dcba[3];
    bus.clr = clr_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic yq, input logic yr,
                            input logic [15:0] cnt, input logic [3:0] mask);
    check({tag, "_y_q"},       32'(bus.y_q),       32'(yq));
    check({tag, "_y_rise"},    32'(bus.y_rise),    32'(yr));
    check({tag, "_hit_cnt"},   32'(bus.hit_cnt),   32'(cnt));
    check({tag, "_seen_mask"}, 32'(bus.seen_mask), 32'(mask));
  endtask

  initial begin
    logic [15:0] sweep_exp;
    int          rise_cnt;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(4'b0000, 1'b0);
    bus_s.a = 1'b0; bus_s.b = 1'b0; bus_s.c = 1'b0; bus_s.d = 1'b0; bus_s.clr = 1'b0;

    // Combinational path
    #10;
    check("y_all_zero", 32'(bus.y), 32'd1 - 32'd1);
    drive(4'b0010, 1'b0); #10; check("y_walk_b",    32'(bus.y), 32'd1);
    drive(4'b0110, 1'b0); #10; check("y_walk_bc",   32'(bus.y), 32'd1);
    drive(4'b0111, 1'b0); #10; check("y_walk_abc",  32'(bus.y), 32'd1);
    drive(4'b1111, 1'b0); #10; check("y_walk_abcd", 32'(bus.y), 32'd1);

    // Scoreboard for the exhaustive sweep: y is 0 only for index 0
    sweep_exp = 16'hFFFE;
    for (int i = 0; i < 16; i++) exp_q.push_back(sweep_exp[i]);
    for (int i = 0; i < 16; i++) begin
      logic [0:0] e;
      drive(4'(i), 1'b0);
      #1;
      e = exp_q.pop_front();
      check($sformatf("y_sweep_%0d", i), 32'(bus.y), 32'(e));
    end

    // Reset for two edges
    drive(4'b0000, 1'b0);
    tick(); tick();
    check_regs("reset", 1'b0, 1'b0, 16'd0, 4'b0000);
    check("sat_reset_cnt", 32'(bus_s.hit_cnt), 32'd0);
    rst = 1'b0;

    // b high for three edges
    drive(4'b0010, 1'b0);
    rise_cnt = 0;
    tick(); rise_cnt += int'(bus.y_rise);
    check_regs("b_edge1", 1'b1, 1'b1, 16'd1, 4'b0010);
    tick(); rise_cnt += int'(bus.y_rise);
    check_regs("b_edge2", 1'b1, 1'b0, 16'd2, 4'b0010);
    tick(); rise_cnt += int'(bus.y_rise);
    check_regs("b_edge3", 1'b1, 1'b0, 16'd3, 4'b0010);
    check("rise_pulse_count", 32'(rise_cnt), 32'd1);

    // Clear with y=1: stats zeroed, y_q unaffected
    drive(4'b0010, 1'b1);
    tick();
    check_regs("clr", 1'b1, 1'b0, 16'd0, 4'b0000);

    // Accumulate after clear
    drive(4'b1011, 1'b0);
    tick();
    check_regs("after_clr", 1'b1, 1'b0, 16'd1, 4'b1011);
    drive(4'b0000, 1'b0);
    tick();
    check_regs("idle", 1'b0, 1'b0, 16'd1, 4'b1011);
    drive(4'b0100, 1'b0);
    tick();
    check_regs("rise_again", 1'b1, 1'b1, 16'd2, 4'b1111);

    // rst and clr together: reset wins
    rst = 1'b1;
    drive(4'b1111, 1'b1);
    tick();
    check_regs("rst_clr", 1'b0, 1'b0, 16'd0, 4'b0000);
    rst = 1'b0;
    drive(4'b0000, 1'b0);

    // Saturation on the 2-bit counter
    bus_s.a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("sat_edge%0d", k), 32'(bus_s.hit_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    check("sat_mask", 32'(bus_s.seen_mask), 32'h1);

    // Mid-operation reset on the saturated instance
    rst = 1'b1;
    tick();
    check("sat_rst_cnt", 32'(bus_s.hit_cnt), 32'd0);
    check("sat_rst_y_q", 32'(bus_s.y_q), 32'd0);
    check("sat_y_during_rst", 32'(bus_s.y), 32'd1);
    rst = 1'b0;

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
